divsqrt_arbiter: RTL and testbench

- Shares one iterative divider and one square-root unit (I16.F16) among NUM_REQ requesters, e.g. several Cholesky/inversion engines working on different pixels.
- Round-robin arbitration issues at most one operation per cycle into the divider or the sqrt unit.
- Per-unit tag FIFOs record which requester owns each in-flight operation, so each result is returned to the correct requester.
- Sits between the inversion engines and the shared divider/sqrt instances.

---
 rtl/divsqrt_arbiter_if.sv | 47 ++++
 rtl/divsqrt_arbiter.sv | 176 +++++++++++++++++
 tb/tb_divsqrt_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divsqrt_arbiter_if.sv
// rtl/divsqrt_arbiter_if.sv - requester and divider/sqrt unit signals of the shared divsqrt arbiter
interface divsqrt_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0] req_n;
    logic [NUM_REQ*DATA_W-1:0] req_d;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      div_in_valid;
    logic [DATA_W-1:0]         div_n;
    logic [DATA_W-1:0]         div_d;
    logic                      div_ready;
    logic                      div_out_valid;
    logic [DATA_W-1:0]         div_out;

    logic                      sqrt_in_valid;
    logic [DATA_W-1:0]         sqrt_n;
    logic                      sqrt_ready;
    logic                      sqrt_out_valid;
    logic [DATA_W-1:0]         sqrt_out;

    logic [NUM_REQ-1:0]        div_rsp_valid;
    logic [DATA_W-1:0]         div_rsp_data;
    logic [NUM_REQ-1:0]        sqrt_rsp_valid;
    logic [DATA_W-1:0]         sqrt_rsp_data;
    logic                      busy;
    logic                      err;

    modport slave (
        input  req_valid, req_op, req_n, req_d,
        input  div_ready, div_out_valid, div_out,
        input  sqrt_ready, sqrt_out_valid, sqrt_out,
        output req_ready, div_in_valid, div_n, div_d, sqrt_in_valid, sqrt_n,
        output div_rsp_valid, div_rsp_data, sqrt_rsp_valid, sqrt_rsp_data, busy, err
    );

    modport master (
        output req_valid, req_op, req_n, req_d,
        output div_ready, div_out_valid, div_out,
        output sqrt_ready, sqrt_out_valid, sqrt_out,
        input  req_ready, div_in_valid, div_n, div_d, sqrt_in_valid, sqrt_n,
        input  div_rsp_valid, div_rsp_data, sqrt_rsp_valid, sqrt_rsp_data, busy, err
    );
endinterface

// File: rtl/divsqrt_arbiter.sv
// rtl/divsqrt_arbiter.sv - round-robin sharing of one divider and one sqrt unit among requesters
module divsqrt_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_tag,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module divsqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input logic              clk,
    input logic              rst,
    divsqrt_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     winner;
    logic               grant;
    logic               win_op;
    int                 idx;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] req_ready;
    logic [DATA_W-1:0]  sel_n;
    logic [DATA_W-1:0]  sel_d;

    logic               div_iv, sqrt_iv;
    logic [DATA_W-1:0]  div_n_q, div_d_q, sqrt_n_q;
    logic [NUM_REQ-1:0] div_rsp_valid_q, sqrt_rsp_valid_q;
    logic [DATA_W-1:0]  div_rsp_data_q, sqrt_rsp_data_q;
    logic               err_q;

    logic               div_full, div_empty, sqrt_full, sqrt_empty;
    logic [IDW-1:0]     div_head, sqrt_head;
    logic               div_elig, sqrt_elig;
    logic               div_push, sqrt_push, div_pop, sqrt_pop;

    // A unit just strobed cannot take another operand on the following cycle.
    assign div_elig  = bus.div_ready  && !div_iv  && !div_full;
    assign sqrt_elig = bus.sqrt_ready && !sqrt_iv && !sqrt_full;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = !rst && bus.req_valid[i] && (bus.req_op[i] ? sqrt_elig : div_elig);
        end
    end

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant && cand[IDW'(idx)]) begin
                grant  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    assign win_op    = bus.req_op[winner];
    assign sel_n     = bus.req_n[int'(winner)*DATA_W +: DATA_W];
    assign sel_d     = bus.req_d[int'(winner)*DATA_W +: DATA_W];
    assign div_push  = grant && !win_op;
    assign sqrt_push = grant && win_op;
    assign div_pop   = bus.div_out_valid  && !div_empty;
    assign sqrt_pop  = bus.sqrt_out_valid && !sqrt_empty;

    divsqrt_tag_fifo #(.DEPTH(MAX_OUT), .W(IDW)) u_div_tags (
        .clk(clk), .rst(rst), .push(div_push), .push_tag(winner), .pop(div_pop),
        .head(div_head), .full(div_full), .empty(div_empty)
    );

    divsqrt_tag_fifo #(.DEPTH(MAX_OUT), .W(IDW)) u_sqrt_tags (
        .clk(clk), .rst(rst), .push(sqrt_push), .push_tag(winner), .pop(sqrt_pop),
        .head(sqrt_head), .full(sqrt_full), .empty(sqrt_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr              <= '0;
            div_iv           <= 1'b0;
            sqrt_iv          <= 1'b0;
            div_n_q          <= '0;
            div_d_q          <= '0;
            sqrt_n_q         <= '0;
            div_rsp_valid_q  <= '0;
            div_rsp_data_q   <= '0;
            sqrt_rsp_valid_q <= '0;
            sqrt_rsp_data_q  <= '0;
            err_q            <= 1'b0;
        end else begin
            div_iv  <= div_push;
            sqrt_iv <= sqrt_push;
            if (grant) begin
                ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                if (win_op) begin
                    sqrt_n_q <= sel_n;
                end else begin
                    div_n_q <= sel_n;
                    div_d_q <= sel_d;
                end
            end
            div_rsp_valid_q  <= '0;
            sqrt_rsp_valid_q <= '0;
            if (div_pop) begin
                div_rsp_valid_q[div_head] <= 1'b1;
                div_rsp_data_q            <= bus.div_out;
            end
            if (sqrt_pop) begin
                sqrt_rsp_valid_q[sqrt_head] <= 1'b1;
                sqrt_rsp_data_q             <= bus.sqrt_out;
            end
            // A result with no owner is dropped and flagged.
            if ((bus.div_out_valid && div_empty) || (bus.sqrt_out_valid && sqrt_empty)) err_q <= 1'b1;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.div_in_valid   = div_iv;
    assign bus.div_n          = div_n_q;
    assign bus.div_d          = div_d_q;
    assign bus.sqrt_in_valid  = sqrt_iv;
    assign bus.sqrt_n         = sqrt_n_q;
    assign bus.div_rsp_valid  = div_rsp_valid_q;
    assign bus.div_rsp_data   = div_rsp_data_q;
    assign bus.sqrt_rsp_valid = sqrt_rsp_valid_q;
    assign bus.sqrt_rsp_data  = sqrt_rsp_data_q;
    assign bus.err            = err_q;
    assign bus.busy           = (|bus.req_valid) || !div_empty || !sqrt_empty || div_iv || sqrt_iv;
endmodule

// File: tb/tb_divsqrt_arbiter.sv
// tb/tb_divsqrt_arbiter.sv - directed self-checking bench for divsqrt_arbiter
module tb_divsqrt_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divsqrt_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    divsqrt_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_OUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fx_div(input logic [31:0] n, input logic [31:0] d);
        logic [63:0] t;
        t = {32'h0, n} << 16;
        if (d == 0) return 32'hffff_ffff;
        return 32'(t / {32'h0, d});
    endfunction

    function automatic logic [31:0] fx_sqrt(input logic [31:0] n);
        logic [63:0] x;
        logic [63:0] r;
        logic [63:0] t;
        x = {16'h0, n, 16'h0};
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'h1 << b);
            if (t * t <= x) r = t;
        end
        return r[31:0];
    endfunction

    // Unit models: in_valid seen in cycle c returns its result in cycle c+lat.
    int          cyc = 0;
    int          div_lat = 5;
    int          sqrt_lat = 4;
    bit          div_hold = 1'b0;
    int          div_kick = 0;
    int          div_kick_done = 0;
    logic [31:0] dq_data[$];
    int          dq_due[$];
    logic [31:0] sq_data[$];
    int          sq_due[$];

    always @(posedge clk) begin
        if (bus.div_in_valid === 1'b1) begin
            dq_data.push_back(fx_div(bus.div_n, bus.div_d));
            dq_due.push_back(cyc + div_lat);
        end
        if (bus.sqrt_in_valid === 1'b1) begin
            sq_data.push_back(fx_sqrt(bus.sqrt_n));
            sq_due.push_back(cyc + sqrt_lat);
        end
        cyc++;
        #1;
        bus.div_out_valid  = 1'b0;
        bus.sqrt_out_valid = 1'b0;
        if (div_kick != div_kick_done) begin
            div_kick_done++;
            bus.div_out_valid = 1'b1;
            if (dq_data.size() > 0) begin
                bus.div_out = dq_data.pop_front();
                void'(dq_due.pop_front());
            end else begin
                bus.div_out = 32'hdead_beef;
            end
        end else if (!div_hold && dq_due.size() > 0 && dq_due[0] <= cyc) begin
            bus.div_out_valid = 1'b1;
            bus.div_out       = dq_data.pop_front();
            void'(dq_due.pop_front());
        end
        if (sq_due.size() > 0 && sq_due[0] <= cyc) begin
            bus.sqrt_out_valid = 1'b1;
            bus.sqrt_out       = sq_data.pop_front();
            void'(sq_due.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit op, input logic [31:0] n, input logic [31:0] d);
        bus.req_valid[i]         = v;
        bus.req_op[i]            = op;
        bus.req_n[i*DW +: DW]    = n;
        bus.req_d[i*DW +: DW]    = d;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drops each requester once granted; returns how many grants were seen.
    task automatic run_grants(input int want, output int got);
        logic [NR-1:0] g;
        got = 0;
        for (int c = 0; c < 40 && got < want; c++) begin
            @(negedge clk);
            g = bus.req_ready;
            tick();
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    bus.req_valid[i] = 1'b0;
                    got++;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          exp_order[5] = '{0, 1, 2, 3, 0};
    int          exp_rsp_req[$];
    logic [31:0] exp_rsp_data[$];
    int          kc[NR];
    int          ngrant, nrsp, last_c, gi, got, gw, er;
    logic [31:0] ed;
    logic [NR-1:0] g, acc;
    bit          seen;

    initial begin
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_n      = '0;
        bus.req_d      = '0;
        bus.div_ready  = 1'b1;
        bus.sqrt_ready = 1'b1;
        repeat (3) tick();

        @(negedge clk);
        check("rst req_ready", bus.req_ready, 0);
        check("rst div_in_valid", bus.div_in_valid, 0);
        check("rst sqrt_in_valid", bus.sqrt_in_valid, 0);
        check("rst div_rsp_valid", bus.div_rsp_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst err", bus.err, 0);
        check("rst div_n", bus.div_n, 0);
        tick();
        rst = 1'b0;

        // Single divide from requester 2
        set_req(2, 1, 0, 32'h0006_0000, 32'h0002_0000);
        @(negedge clk);
        check("A grant", bus.req_ready, 4'b0100);
        check("A busy", bus.busy, 1);
        tick();
        set_req(2, 0, 0, 32'h0006_0000, 32'h0002_0000);
        @(negedge clk);
        check("A div_in_valid", bus.div_in_valid, 1);
        check("A div_n", bus.div_n, 32'h0006_0000);
        check("A div_d", bus.div_d, 32'h0002_0000);
        check("A sqrt_in_valid", bus.sqrt_in_valid, 0);
        check("A no regrant", bus.req_ready, 0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.div_out_valid === 1'b1) seen = 1'b1;
        end
        check("A out seen", seen, 1);
        check("A rsp not early", bus.div_rsp_valid, 0);
        @(negedge clk);
        check("A rsp route", bus.div_rsp_valid, 4'b0100);
        check("A rsp data", bus.div_rsp_data, 32'h0003_0000);
        @(negedge clk);
        check("A rsp one cycle", bus.div_rsp_valid, 0);

        // Four requesters dividing continuously
        do_reset();
        div_lat = 3;
        for (int i = 0; i < NR; i++) begin
            kc[i] = 0;
            set_req(i, 1, 0, 32'h0001_0000 * (i + 1), 32'h0001_0000);
        end
        ngrant = 0;
        nrsp   = 0;
        last_c = 0;
        for (int c = 0; c < 60 && nrsp < 5; c++) begin
            @(negedge clk);
            if (bus.div_rsp_valid != 0) begin
                if (exp_rsp_req.size() == 0) begin
                    check("B extra rsp", bus.div_rsp_valid, 0);
                end else begin
                    er = exp_rsp_req.pop_front();
                    ed = exp_rsp_data.pop_front();
                    check("B rsp route", bus.div_rsp_valid, 64'h1 << er);
                    check("B rsp data", bus.div_rsp_data, ed);
                    nrsp++;
                end
            end
            g  = bus.req_ready;
            gi = -1;
            for (int i = 0; i < NR; i++) if (g[i]) gi = i;
            if (gi >= 0 && ngrant < 5) begin
                check("B grant order", g, 64'h1 << exp_order[ngrant]);
                if (ngrant > 0) check("B issue spacing", c - last_c, 2);
                last_c = c;
                exp_rsp_req.push_back(gi);
                exp_rsp_data.push_back(32'h0001_0000 * (gi + 1) + kc[gi] * 32'h100);
                ngrant++;
            end
            tick();
            if (gi >= 0) begin
                if (ngrant >= 5) begin
                    bus.req_valid = '0;
                end else begin
                    kc[gi]++;
                    set_req(gi, 1, 0, 32'h0001_0000 * (gi + 1) + kc[gi] * 32'h100, 32'h0001_0000);
                end
            end
        end
        check("B grants", ngrant, 5);
        check("B responses", nrsp, 5);

        // Sqrt and divide requested together
        do_reset();
        div_lat  = 3;
        sqrt_lat = 4;
        set_req(0, 1, 1, 32'h0004_0000, 32'h0);
        set_req(1, 1, 0, 32'h0006_0000, 32'h0003_0000);
        @(negedge clk);
        check("C first grant", bus.req_ready, 4'b0001);
        tick();
        set_req(0, 0, 1, 32'h0004_0000, 32'h0);
        @(negedge clk);
        check("C second grant", bus.req_ready, 4'b0010);
        check("C sqrt_in_valid", bus.sqrt_in_valid, 1);
        check("C sqrt_n", bus.sqrt_n, 32'h0004_0000);
        tick();
        set_req(1, 0, 0, 32'h0006_0000, 32'h0003_0000);
        @(negedge clk);
        check("C div_in_valid", bus.div_in_valid, 1);
        check("C div_n", bus.div_n, 32'h0006_0000);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.sqrt_rsp_valid != 0) seen = 1'b1;
        end
        check("C sqrt rsp seen", seen, 1);
        check("C sqrt rsp route", bus.sqrt_rsp_valid, 4'b0001);
        check("C sqrt rsp data", bus.sqrt_rsp_data, 32'h0002_0000);
        check("C div rsp same cycle", bus.div_rsp_valid, 4'b0010);
        check("C div rsp data", bus.div_rsp_data, 32'h0002_0000);

        // Divider tag FIFO full
        do_reset();
        div_hold = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1, 0, 32'h0001_0000 * (i + 1), 32'h0001_0000);
        run_grants(4, got);
        check("D four granted", got, 4);
        set_req(0, 1, 0, 32'h0005_0000, 32'h0001_0000);
        set_req(1, 1, 1, 32'h0009_0000, 32'h0);
        @(negedge clk);
        check("D sqrt still granted", bus.req_ready, 4'b0010);
        tick();
        set_req(1, 0, 1, 32'h0009_0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("D full blocks", bus.req_ready, 0);
            tick();
        end
        @(negedge clk);
        check("D busy", bus.busy, 1);
        div_kick++;
        @(negedge clk);
        check("D blocked in pulse cycle", bus.req_ready, 0);
        gw = -1;
        for (int k = 1; k <= 3 && gw < 0; k++) begin
            @(negedge clk);
            if (k == 1) check("D pop rsp route", bus.div_rsp_valid, 4'b0001);
            if (bus.req_ready != 0) gw = k;
        end
        check("D fifth grant", bus.req_ready, 4'b0001);
        check("D fifth grant delay", (gw >= 1 && gw <= 2), 1);
        tick();
        set_req(0, 0, 0, 32'h0005_0000, 32'h0001_0000);

        // Result with nothing in flight
        do_reset();
        @(negedge clk);
        div_kick++;
        @(negedge clk);
        check("E err before", bus.err, 0);
        @(negedge clk);
        check("E err set", bus.err, 1);
        check("E no rsp", bus.div_rsp_valid, 0);
        repeat (3) @(negedge clk);
        check("E err sticky", bus.err, 1);
        check("E busy", bus.busy, 0);

        // Reset with divides in flight
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1, 0, 32'h0002_0000, 32'h0001_0000);
        run_grants(3, got);
        check("F three granted", got, 3);
        @(negedge clk);
        check("F busy in flight", bus.busy, 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("F rst req_ready", bus.req_ready, 0);
        check("F rst div_in_valid", bus.div_in_valid, 0);
        check("F rst div_n", bus.div_n, 0);
        check("F rst busy", bus.busy, 0);
        check("F rst err", bus.err, 0);
        div_hold = 1'b0;
        tick();
        rst = 1'b0;
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acc = acc | bus.div_rsp_valid;
        end
        check("F no late rsp", acc, 0);
        check("F late err", bus.err, 1);
        check("F idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
